// File: rtl/top_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// top_pkg: opcodes, control enums and immediate helper. Rev 1.0
// ------------------------------------------------------------------
package top_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU,
    RES_MEM,
    RES_PC4
  } result_src_e;

  function automatic logic [31:0] ext_imm(input logic [31:7] ins, input imm_src_e src);
    case (src)
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return {{20{ins[31]}}, ins[31:20]};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem: 64-word data memory, synchronous write, combinational read. Rev 1.0
// ------------------------------------------------------------------
module dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [31:0] mem [64];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end

  assign rd = mem[addr];
endmodule
`default_nettype wire

// File: rtl/imem.sv
`default_nettype none
// ------------------------------------------------------------------
// imem: 64-word read-only instruction memory, combinational read. Rev 1.0
// ------------------------------------------------------------------
module imem (
    input  logic [5:0]  addr,
    output logic [31:0] rd
);
    logic [31:0] mem [64];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00C0_0193;
        mem[2] = 32'h4021_83B3;
        mem[3] = 32'h0670_2023;
        mem[4] = 32'h00A0_0313;
        mem[5] = 32'h0660_2223;
        mem[6] = 32'h0000_0063;
    end

    assign rd = mem[addr];
endmodule
`default_nettype wire

// File: rtl/riscvsingle.sv
`default_nettype none
// ------------------------------------------------------------------
// riscvsingle: single-cycle RV32I subset datapath and control. Rev 1.0
// ------------------------------------------------------------------
module riscvsingle
  import top_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  output logic [5:0]  imem_addr,
  output logic        mem_write,
  output logic [31:0] alu_result,
  output logic [31:0] write_data
);
  logic [31:0] pc, pc_plus4, pc_target, pc_next;
  logic [31:0] imm_ext, src_a, src_b, result;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, is_store, branch, jump, alu_src, zero, rf_we;
  imm_src_e    imm_src;
  result_src_e result_src;
  alu_ctrl_e   alu_ctrl;
  logic [31:0] rf [32];

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Unsupported opcode/funct combinations fall through with every control low.
  always_comb begin
    reg_write  = 1'b0;
    is_store   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    result_src = RES_ALU;
    alu_ctrl   = ALU_ADD;
    case (opcode)
      OPC_LOAD: if (funct3 == 3'b010) begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OPC_STORE: if (funct3 == 3'b010) begin
        is_store = 1'b1;
        alu_src  = 1'b1;
        imm_src  = IMM_S;
      end
      OPC_OP: begin
        reg_write = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: alu_ctrl = ALU_ADD;
          {7'b0100000, 3'b000}: alu_ctrl = ALU_SUB;
          {7'b0000000, 3'b111}: alu_ctrl = ALU_AND;
          {7'b0000000, 3'b110}: alu_ctrl = ALU_OR;
          {7'b0000000, 3'b010}: alu_ctrl = ALU_SLT;
          default:              reg_write = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        case (funct3)
          3'b000:  alu_ctrl = ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          3'b010:  alu_ctrl = ALU_SLT;
          default: reg_write = 1'b0;
        endcase
      end
      OPC_BRANCH: if (funct3 == 3'b000) begin
        branch   = 1'b1;
        imm_src  = IMM_B;
        alu_ctrl = ALU_SUB;
      end
      OPC_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        imm_src    = IMM_J;
        result_src = RES_PC4;
      end
      default: ;
    endcase
  end

  assign imm_ext    = ext_imm(instr[31:7], imm_src);
  assign src_a      = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign write_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign src_b      = alu_src ? imm_ext : write_data;

  always_comb begin
    alu_result = src_a + src_b;
    case (alu_ctrl)
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = src_a + src_b;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_ext;
  assign pc_next   = (jump || (branch && zero)) ? pc_target : pc_plus4;

  always_comb begin
    result = alu_result;
    case (result_src)
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      default: result = alu_result;
    endcase
  end

  // Architectural writes are gated off while reset is held low.
  assign mem_write = is_store & reset;
  assign rf_we     = reg_write & reset;
  assign imem_addr = pc[7:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'd0;
    else        pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rf_we && (rd != 5'd0)) rf[rd] <= result;
  end
endmodule
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ------------------------------------------------------------------
// top: single-cycle RV32I subset core with 64-word IMEM and DMEM. Rev 1.0
// ------------------------------------------------------------------
module top (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite
);
  logic [5:0]  imem_addr;
  logic [31:0] instr, read_data;

  riscvsingle u_cpu (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .read_data  (read_data),
    .imem_addr  (imem_addr),
    .mem_write  (MemWrite),
    .alu_result (DataAdr),
    .write_data (WriteData)
  );

  imem u_imem (
    .addr (imem_addr),
    .rd   (instr)
  );

  dmem u_dmem (
    .clk  (clk),
    .we   (MemWrite),
    .addr (DataAdr[7:2]),
    .wd   (WriteData),
    .rd   (read_data)
  );
endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_top: directed program with a store scoreboard for top. Rev 1.0
// ------------------------------------------------------------------
module tb_top;
  localparam logic [6:0] T_OPI = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WriteData, DataAdr;
  logic        MemWrite;

  int compared   = 0;
  int mismatched = 0;
  int store100_cyc;
  logic [63:0] exp_q[$];
  logic [31:0] prog[$];

  top dut (
    .clk       (clk),
    .reset     (reset),
    .WriteData (WriteData),
    .DataAdr   (DataAdr),
    .MemWrite  (MemWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input int f3, input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input int addr, input int data);
    exp_q.push_back({addr[31:0], data[31:0]});
  endtask

  task automatic push_program_stores();
    push_exp(96, 7);   push_exp(96, 0);  push_exp(96, 1);  push_exp(96, 52);
    push_exp(96, 17);  push_exp(100, 10); push_exp(96, 22); push_exp(96, 0);
    push_exp(96, 2);   push_exp(96, 5);
  endtask

  task automatic build_program();
    prog.delete();
    prog.push_back(enc_i(T_OPI, 0, 2, 0, 5));       // 0  x2=5
    prog.push_back(enc_i(T_OPI, 0, 3, 0, 12));      // 1  x3=12
    prog.push_back(enc_r(32, 2, 3, 0, 7));          // 2  sub x7,x3,x2
    prog.push_back(enc_s(7, 0, 96));                // 3
    prog.push_back(enc_r(0, 2, 3, 2, 4));           // 4  slt x4,x3,x2
    prog.push_back(enc_s(4, 0, 96));                // 5
    prog.push_back(enc_r(0, 3, 2, 2, 4));           // 6  slt x4,x2,x3
    prog.push_back(enc_s(4, 0, 96));                // 7
    prog.push_back(enc_b(2, 2, 8));                 // 8  beq taken
    prog.push_back(enc_s(3, 0, 96));                // 9  skipped
    prog.push_back(enc_j(0, 8));                    // 10 jal x0,+8
    prog.push_back(enc_s(3, 0, 96));                // 11 skipped
    prog.push_back(enc_j(1, 8));                    // 12 jal x1,+8
    prog.push_back(enc_s(3, 0, 96));                // 13 skipped
    prog.push_back(enc_s(1, 0, 96));                // 14 x1=52
    prog.push_back(enc_r(0, 2, 3, 7, 8));           // 15 and 4
    prog.push_back(enc_r(0, 2, 3, 6, 9));           // 16 or 13
    prog.push_back(enc_r(0, 9, 8, 0, 10));          // 17 add 17
    prog.push_back(enc_s(10, 0, 96));               // 18
    prog.push_back(enc_i(T_LD, 2, 5, 0, 96));       // 19 lw x5
    prog.push_back(enc_i(T_OPI, 0, 6, 5, -7));      // 20 x6=10
    prog.push_back(enc_s(6, 0, 100));               // 21 store 10 @100
    prog.push_back(enc_i(T_OPI, 6, 11, 2, 8));      // 22 ori 13
    prog.push_back(enc_i(T_OPI, 7, 12, 3, -8));     // 23 andi 8
    prog.push_back(enc_i(T_OPI, 2, 13, 2, 6));      // 24 slti 1
    prog.push_back(enc_r(0, 12, 11, 0, 14));        // 25 21
    prog.push_back(enc_r(0, 13, 14, 0, 14));        // 26 22
    prog.push_back(enc_r(1, 14, 14, 0, 14));        // 27 unsupported funct7
    prog.push_back(enc_s(14, 0, 96));               // 28 22
    prog.push_back(enc_i(T_OPI, 0, 0, 0, 5));       // 29 write to x0
    prog.push_back(enc_s(0, 0, 96));                // 30 0
    prog.push_back(enc_i(T_OPI, 0, 15, 0, -3));     // 31 x15=-3
    prog.push_back(enc_r(0, 2, 15, 2, 16));         // 32 slt signed 1
    prog.push_back(enc_i(T_OPI, 2, 17, 15, -2));    // 33 slti 1
    prog.push_back(enc_r(0, 17, 16, 0, 18));        // 34 2
    prog.push_back(enc_s(18, 0, 96));               // 35
    prog.push_back(enc_b(2, 3, 8));                 // 36 beq not taken
    prog.push_back(enc_s(2, 0, 96));                // 37 5
    prog.push_back(32'hFFFF_FFFF);                  // 38 unknown opcode
    prog.push_back(enc_b(0, 0, 0));                 // 39 spin
    for (int i = 0; i < 64; i++)
      dut.u_imem.mem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
  endtask

  task automatic run_program(input int n);
    logic [63:0] want;
    store100_cyc = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (MemWrite !== 1'b0) begin
        compared++;
        assert (exp_q.size() != 0) else begin
          mismatched++;
          $error("FAIL extra_store observed addr=%0d data=%0d expected no store", DataAdr, WriteData);
        end
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("store", {DataAdr, WriteData}, want);
        end
        if (DataAdr == 32'd100 && store100_cyc < 0) store100_cyc = k;
      end
    end
    compared++;
    assert (store100_cyc > 0 && store100_cyc < 24) else begin
      mismatched++;
      $error("FAIL store100_cycle observed=%0d expected 1..23", store100_cyc);
    end
    check("store_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    #1;
    build_program();
    // Word 0 temporarily holds a store to prove MemWrite is gated during reset.
    dut.u_imem.mem[0] = enc_s(0, 0, 96);
    repeat (2) begin
      @(negedge clk);
      check("reset_memwrite", 64'(MemWrite), 64'd0);
      check("reset_dataadr", 64'(DataAdr), 64'd96);
    end
    dut.u_imem.mem[0] = prog[0];
    #1;
    check("reset_fetch_pc0", 64'(DataAdr), 64'd5);
    reset = 1'b1;
    push_program_stores();
    run_program(50);

    check("spin_dataadr", 64'(DataAdr), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("midreset_dataadr", 64'(DataAdr), 64'd5);
    check("midreset_memwrite", 64'(MemWrite), 64'd0);
    @(negedge clk);
    check("midreset_hold", 64'(DataAdr), 64'd5);
    reset = 1'b1;
    push_program_stores();
    run_program(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
